// File: rtl/grad_pkg.sv
// Shared constants, state encoding and helpers for the gradient accumulator.
package grad_pkg;

    localparam logic [31:0] Q16_ONE = 32'h0001_0000;

    localparam int unsigned DefInWidth   = 32;
    localparam int unsigned DefAccWidth  = 40;
    localparam int unsigned DefOutWidth  = 32;
    localparam int unsigned DefGroupLen  = 3;
    localparam int unsigned DefFifoDepth = 16;

    typedef enum logic {
        StIdle,
        StAccum
    } state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        if (value > 1) begin
            for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
                res++;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/grad_accum_if.sv
// Term stream in (valid/last, no ready) and result stream out (AXIS with backpressure).
interface grad_accum_if import grad_pkg::*; #(
    parameter int unsigned IN_WIDTH  = DefInWidth,
    parameter int unsigned OUT_WIDTH = DefOutWidth
);
    logic [IN_WIDTH-1:0]  s_tdata;
    logic                 s_tvalid;
    logic                 s_tlast;
    logic [OUT_WIDTH-1:0] m_tdata;
    logic                 m_tvalid;
    logic                 m_tready;
    logic                 m_tlast;

    // Environment side: produces terms, consumes results.
    modport master (
        output s_tdata, s_tvalid, s_tlast, m_tready,
        input  m_tdata, m_tvalid, m_tlast
    );

    // Accumulator side.
    modport slave (
        input  s_tdata, s_tvalid, s_tlast, m_tready,
        output m_tdata, m_tvalid, m_tlast
    );
endinterface

// File: rtl/grad_fifo.sv
// Single-clock FIFO with registered head output; a write into a full FIFO is
// accepted when a read happens on the same edge.
module grad_fifo import grad_pkg::*; #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = DefFifoDepth
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_ack,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);
    localparam int unsigned PtrW = clog2(DEPTH);
    typedef logic [PtrW:0] count_t;
    localparam count_t FullCount = count_t'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q, rd_nxt;
    count_t           count_q;
    logic [WIDTH-1:0] rd_data_q;
    logic             full, do_wr, do_rd;

    assign empty   = (count_q == '0);
    assign full    = (count_q == FullCount);
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign wr_ack  = do_wr;
    assign rd_nxt  = rd_ptr_q + PtrW'(1);
    assign rd_data = rd_data_q;

    always_ff @(posedge aclk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_data_q <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (do_rd) rd_ptr_q <= rd_nxt;
            unique case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + count_t'(1);
                2'b01:   count_q <= count_q - count_t'(1);
                default: count_q <= count_q;
            endcase
            // Head register follows the oldest entry; empty keeps the last value.
            if (do_rd) begin
                if (count_q > count_t'(1)) rd_data_q <= mem_q[rd_nxt];
                else if (do_wr)            rd_data_q <= wr_data;
            end else if (empty && do_wr) begin
                rd_data_q <= wr_data;
            end
        end
    end
endmodule

// File: rtl/grad_accum.sv
// Sums groups of GROUP_LEN signed Q16 terms and queues narrowed sums on an AXIS master.
// Define GRAD_ACCUM_SAT_EN for saturating narrowing and the sat_hit flag; default wraps.
module grad_accum import grad_pkg::*; #(
    parameter int unsigned IN_WIDTH   = DefInWidth,
    parameter int unsigned ACC_WIDTH  = DefAccWidth,
    parameter int unsigned OUT_WIDTH  = DefOutWidth,
    parameter int unsigned GROUP_LEN  = DefGroupLen,
    parameter int unsigned FIFO_DEPTH = DefFifoDepth
) (
    input  logic        aclk,
    input  logic        aresetn,
    grad_accum_if.slave bus,
    output logic        overflow,
    output logic [15:0] grp_cnt
`ifdef GRAD_ACCUM_SAT_EN
    ,
    output logic        sat_hit
`endif
);
    localparam int unsigned CntW = clog2(GROUP_LEN) + 1;

    state_e                       state_q, state_d;
    logic signed [ACC_WIDTH-1:0]  acc_q, acc_d, term_ext, sum;
    logic [CntW-1:0]              cnt_q, cnt_d, cnt_inc;
    logic                         close, close_q, last_q;
    logic                         res_valid_q, res_last_q;
    logic [OUT_WIDTH-1:0]         res_data_q, narrowed;
    logic                         overflow_q, wr_ack, fifo_empty;
    logic [15:0]                  grp_cnt_q;
    logic [OUT_WIDTH:0]           fifo_out;

    assign term_ext = {{(ACC_WIDTH - IN_WIDTH){bus.s_tdata[IN_WIDTH-1]}}, bus.s_tdata};

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        close   = 1'b0;
        sum     = (state_q == StIdle) ? term_ext : acc_q + term_ext;
        cnt_inc = (state_q == StIdle) ? CntW'(1) : cnt_q + CntW'(1);
        if (bus.s_tvalid) begin
            acc_d   = sum;
            cnt_d   = cnt_inc;
            close   = (cnt_inc == CntW'(GROUP_LEN)) || bus.s_tlast;
            state_d = close ? StIdle : StAccum;
        end
    end

`ifdef GRAD_ACCUM_SAT_EN
    logic [ACC_WIDTH-OUT_WIDTH:0] acc_hi;
    logic                         clamp, sat_hit_q;

    // Fits in OUT_WIDTH only if every bit above the output sign bit matches it.
    always_comb begin
        acc_hi   = acc_q[ACC_WIDTH-1:OUT_WIDTH-1];
        clamp    = !((&acc_hi) || !(|acc_hi));
        narrowed = acc_q[OUT_WIDTH-1:0];
        if (clamp) begin
            narrowed = acc_q[ACC_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                          : {1'b0, {(OUT_WIDTH-1){1'b1}}};
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)            sat_hit_q <= 1'b0;
        else if (close_q && clamp) sat_hit_q <= 1'b1;
    end
    assign sat_hit = sat_hit_q;
`else
    assign narrowed = acc_q[OUT_WIDTH-1:0];
`endif

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            cnt_q       <= '0;
            close_q     <= 1'b0;
            last_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_last_q  <= 1'b0;
            res_data_q  <= '0;
            overflow_q  <= 1'b0;
            grp_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            close_q     <= close;
            last_q      <= bus.s_tvalid && bus.s_tlast;
            res_valid_q <= close_q;
            // acc_q still holds the closed group's sum on the edge after the close.
            if (close_q) begin
                res_data_q <= narrowed;
                res_last_q <= last_q;
            end
            if (res_valid_q && !wr_ack) overflow_q <= 1'b1;
            if (wr_ack)                 grp_cnt_q  <= grp_cnt_q + 16'd1;
        end
    end

    grad_fifo #(
        .WIDTH (OUT_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .aclk    (aclk),
        .aresetn (aresetn),
        .wr_en   (res_valid_q),
        .wr_data ({res_last_q, res_data_q}),
        .wr_ack  (wr_ack),
        .rd_en   (bus.m_tready),
        .rd_data (fifo_out),
        .empty   (fifo_empty)
    );

    assign bus.m_tvalid = !fifo_empty;
    assign bus.m_tlast  = fifo_out[OUT_WIDTH];
    assign bus.m_tdata  = fifo_out[OUT_WIDTH-1:0];
    assign overflow     = overflow_q;
    assign grp_cnt      = grp_cnt_q;
endmodule

// File: tb/tb_grad_accum.sv
// Self-checking bench for grad_accum: directed scenarios plus a randomized run
// against a plain-arithmetic group-sum model.
module tb_grad_accum;
    import grad_pkg::*;

    localparam int unsigned IN_WIDTH   = 32;
    localparam int unsigned ACC_WIDTH  = 40;
    localparam int unsigned OUT_WIDTH  = 32;
    localparam int unsigned GROUP_LEN  = 3;
    localparam int unsigned FIFO_DEPTH = 16;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        overflow;
    logic [15:0] grp_cnt;
`ifdef GRAD_ACCUM_SAT_EN
    logic        sat_hit;
`endif
    int total = 0;
    int bad = 0;

    grad_accum_if #(.IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH)) bus ();

    grad_accum #(
        .IN_WIDTH   (IN_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH),
        .OUT_WIDTH  (OUT_WIDTH),
        .GROUP_LEN  (GROUP_LEN),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .bus      (bus),
        .overflow (overflow),
        .grp_cnt  (grp_cnt)
`ifdef GRAD_ACCUM_SAT_EN
        ,
        .sat_hit  (sat_hit)
`endif
    );

    always #5 aclk = ~aclk;

    function automatic logic [31:0] narrow_ref(input longint s);
`ifdef GRAD_ACCUM_SAT_EN
        if (s > 64'sd2147483647)  return 32'h7FFF_FFFF;
        if (s < -64'sd2147483648) return 32'h8000_0000;
`endif
        return s[31:0];
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic do_reset();
        bus.s_tvalid = 1'b0;
        bus.s_tdata  = '0;
        bus.s_tlast  = 1'b0;
        bus.m_tready = 1'b0;
        aresetn      = 1'b0;
        repeat (2) @(posedge aclk);
        #1 aresetn = 1'b1;
    endtask

    // One term sampled on the next rising edge; returns 1 time unit after it.
    task automatic send(input logic [31:0] d, input logic l);
        bus.s_tvalid = 1'b1;
        bus.s_tdata  = d;
        bus.s_tlast  = l;
        @(posedge aclk);
        #1;
        bus.s_tvalid = 1'b0;
        bus.s_tlast  = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (bus.m_tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid got=%b exp=0", bus.m_tvalid); end
        total++; if (bus.m_tlast !== 1'b0) begin bad++; $display("FAIL reset_tlast got=%b exp=0", bus.m_tlast); end
        total++; if (bus.m_tdata !== 32'h0) begin bad++; $display("FAIL reset_tdata got=%h exp=0", bus.m_tdata); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        total++; if (grp_cnt !== 16'd0) begin bad++; $display("FAIL reset_grp_cnt got=%0d exp=0", grp_cnt); end
    endtask

    task automatic test_basic();
        do_reset();
        send(Q16_ONE, 1'b0);
        send(32'h0002_0000, 1'b0);
        send(32'hFFFF_0000, 1'b0);
        total++; if (bus.m_tvalid !== 1'b0) begin bad++; $display("FAIL basic_early0 got=%b exp=0", bus.m_tvalid); end
        wait_cyc(1);
        total++; if (bus.m_tvalid !== 1'b0) begin bad++; $display("FAIL basic_early1 got=%b exp=0", bus.m_tvalid); end
        wait_cyc(1);
        total++; if (bus.m_tvalid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", bus.m_tvalid); end
        total++; if (bus.m_tdata !== 32'h0002_0000) begin bad++; $display("FAIL basic_data got=%h exp=00020000", bus.m_tdata); end
        total++; if (bus.m_tlast !== 1'b0) begin bad++; $display("FAIL basic_last got=%b exp=0", bus.m_tlast); end
        total++; if (grp_cnt !== 16'd1) begin bad++; $display("FAIL basic_grp_cnt got=%0d exp=1", grp_cnt); end
    endtask

    task automatic test_partial();
        do_reset();
        send(32'h0000_8000, 1'b0);
        send(32'h0000_8000, 1'b1);
        wait_cyc(2);
        total++; if (bus.m_tvalid !== 1'b1) begin bad++; $display("FAIL partial_valid got=%b exp=1", bus.m_tvalid); end
        total++; if (bus.m_tdata !== 32'h0001_0000) begin bad++; $display("FAIL partial_data got=%h exp=00010000", bus.m_tdata); end
        total++; if (bus.m_tlast !== 1'b1) begin bad++; $display("FAIL partial_last got=%b exp=1", bus.m_tlast); end
        bus.m_tready = 1'b1;
        wait_cyc(1);
        bus.m_tready = 1'b0;
        total++; if (bus.m_tvalid !== 1'b0) begin bad++; $display("FAIL partial_popped got=%b exp=0", bus.m_tvalid); end
        repeat (3) send(Q16_ONE, 1'b0);
        wait_cyc(2);
        total++; if (bus.m_tdata !== 32'h0003_0000) begin bad++; $display("FAIL partial_fresh_data got=%h exp=00030000", bus.m_tdata); end
        total++; if (bus.m_tlast !== 1'b0) begin bad++; $display("FAIL partial_fresh_last got=%b exp=0", bus.m_tlast); end
        total++; if (grp_cnt !== 16'd2) begin bad++; $display("FAIL partial_grp_cnt got=%0d exp=2", grp_cnt); end
    endtask

    task automatic test_saturation();
        logic [31:0] exp_d;
`ifdef GRAD_ACCUM_SAT_EN
        exp_d = 32'h7FFF_FFFF;
`else
        exp_d = 32'h7FFF_FFFD;
`endif
        do_reset();
        repeat (3) send(32'h7FFF_FFFF, 1'b0);
        wait_cyc(2);
        total++; if (bus.m_tdata !== exp_d) begin bad++; $display("FAIL sat_data got=%h exp=%h", bus.m_tdata, exp_d); end
`ifdef GRAD_ACCUM_SAT_EN
        total++; if (sat_hit !== 1'b1) begin bad++; $display("FAIL sat_hit got=%b exp=1", sat_hit); end
`endif
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_d [17];
        do_reset();
        for (int g = 0; g < 17; g++) begin
            exp_d[g] = (32'(g) << 16) + 32'd3;
            send(32'(g) << 16, 1'b0);
            send(32'd1, 1'b0);
            send(32'd2, 1'b0);
        end
        wait_cyc(3);
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL bp_overflow got=%b exp=1", overflow); end
        total++; if (grp_cnt !== 16'd16) begin bad++; $display("FAIL bp_grp_cnt got=%0d exp=16", grp_cnt); end
        for (int i = 0; i < 16; i++) begin
            total++; if (!bus.m_tvalid || bus.m_tdata !== exp_d[i]) begin bad++; $display("FAIL bp_drain[%0d] got=%b/%h exp=1/%h", i, bus.m_tvalid, bus.m_tdata, exp_d[i]); end
            bus.m_tready = 1'b1;
            wait_cyc(1);
            bus.m_tready = 1'b0;
        end
        total++; if (bus.m_tvalid !== 1'b0) begin bad++; $display("FAIL bp_empty got=%b exp=0", bus.m_tvalid); end
    endtask

    task automatic test_full_pop();
        logic [31:0] exp_d [17];
        do_reset();
        for (int g = 0; g < 17; g++) begin
            exp_d[g] = (32'(g) << 16) + 32'h0000_0100;
            if (g == 16) begin
                wait_cyc(3);
                total++; if (grp_cnt !== 16'd16) begin bad++; $display("FAIL fp_filled got=%0d exp=16", grp_cnt); end
            end
            send(32'(g) << 16, 1'b0);
            send(32'h0000_0080, 1'b0);
            send(32'h0000_0080, 1'b0);
        end
        // Closing beat was sampled one edge ago; the push lands two edges after it.
        wait_cyc(1);
        bus.m_tready = 1'b1;
        wait_cyc(1);
        bus.m_tready = 1'b0;
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fp_overflow got=%b exp=0", overflow); end
        total++; if (grp_cnt !== 16'd17) begin bad++; $display("FAIL fp_grp_cnt got=%0d exp=17", grp_cnt); end
        for (int i = 1; i < 17; i++) begin
            total++; if (!bus.m_tvalid || bus.m_tdata !== exp_d[i]) begin bad++; $display("FAIL fp_drain[%0d] got=%b/%h exp=1/%h", i, bus.m_tvalid, bus.m_tdata, exp_d[i]); end
            bus.m_tready = 1'b1;
            wait_cyc(1);
            bus.m_tready = 1'b0;
        end
        total++; if (bus.m_tvalid !== 1'b0) begin bad++; $display("FAIL fp_empty got=%b exp=0", bus.m_tvalid); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        repeat (3) send(Q16_ONE, 1'b0);
        send(32'h0005_0000, 1'b0);
        wait_cyc(2);
        aresetn = 1'b0;
        #2;
        total++; if (bus.m_tvalid !== 1'b0 || bus.m_tlast !== 1'b0) begin bad++; $display("FAIL rm_flags got=%b%b exp=00", bus.m_tvalid, bus.m_tlast); end
        total++; if (bus.m_tdata !== 32'h0) begin bad++; $display("FAIL rm_tdata got=%h exp=0", bus.m_tdata); end
        total++; if (overflow !== 1'b0 || grp_cnt !== 16'd0) begin bad++; $display("FAIL rm_counters got=%b/%0d exp=0/0", overflow, grp_cnt); end
        @(posedge aclk);
        #1 aresetn = 1'b1;
        repeat (3) send(Q16_ONE, 1'b0);
        wait_cyc(2);
        total++; if (bus.m_tdata !== 32'h0003_0000) begin bad++; $display("FAIL rm_data got=%h exp=00030000", bus.m_tdata); end
        total++; if (grp_cnt !== 16'd1) begin bad++; $display("FAIL rm_grp_cnt got=%0d exp=1", grp_cnt); end
    endtask

    task automatic test_random();
        logic [32:0] exp_q[$];
        logic [32:0] e;
        longint      acc;
        int          n, groups;
        logic        v, l;
        logic [31:0] d;
        acc = 0;
        n = 0;
        groups = 0;
        do_reset();
        for (int cyc = 0; cyc < 700; cyc++) begin
            if (cyc < 600) begin
                v = ($urandom_range(0, 3) != 0);
                d = $urandom;
                l = ($urandom_range(0, 7) == 0);
            end else begin
                v = 1'b0;
                d = '0;
                l = 1'b0;
            end
            bus.s_tvalid = v;
            bus.s_tdata  = d;
            bus.s_tlast  = l;
            bus.m_tready = (cyc >= 600) || ($urandom_range(0, 3) != 0);
            if (v) begin
                acc += longint'(signed'(d));
                n++;
                if (n == int'(GROUP_LEN) || l) begin
                    exp_q.push_back({l, narrow_ref(acc)});
                    groups++;
                    acc = 0;
                    n = 0;
                end
            end
            @(negedge aclk);
            if (bus.m_tvalid && bus.m_tready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL rand_extra got=%b/%h exp=none", bus.m_tlast, bus.m_tdata);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.m_tlast, bus.m_tdata} !== e) begin
                        bad++;
                        $display("FAIL rand_beat got=%b/%h exp=%b/%h", bus.m_tlast, bus.m_tdata, e[32], e[31:0]);
                    end
                end
            end
            @(posedge aclk);
            #1;
        end
        bus.s_tvalid = 1'b0;
        bus.m_tready = 1'b0;
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rand_pending got=%0d exp=0", exp_q.size()); end
        total++; if (grp_cnt !== 16'(groups)) begin bad++; $display("FAIL rand_grp_cnt got=%0d exp=%0d", grp_cnt, groups); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rand_overflow got=%b exp=0", overflow); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_partial();
        test_saturation();
        test_backpressure();
        test_full_pop();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/grad_accum.md
# grad_accum

Downstream stage of the point-processing pipeline. It consumes the signed Q16 gradient-term stream produced by the per-point processing stage, which has valid/last but no ready. It sums each group of GROUP_LEN consecutive terms (one group per transformed point), narrows the sum to OUT_WIDTH, and buffers the results in a FIFO. The results leave on an AXIS master with full backpressure toward DMA S2MM.

## Interface
- IN_WIDTH, 32: width of incoming signed Q16 term.
- ACC_WIDTH, 40: internal accumulator width, signed; must be ≥ IN_WIDTH + clog2(GROUP_LEN).
- OUT_WIDTH, 32: width of emitted signed Q16 sum.
- GROUP_LEN, 3: terms per group (ORI_NUM of the upstream stage); ≥ 1.
- FIFO_DEPTH, 16: result FIFO entries, power of two.

- aclk  in  1  clock; all logic on rising edge.
- aresetn  in  1  reset, asynchronous, active-low.
- s_tdata  in  IN_WIDTH  signed Q16 term.
- s_tvalid  in  1  term valid; upstream cannot stall, every valid beat is consumed.
- s_tlast  in  1  last term of the frame.
- m_tdata  out  OUT_WIDTH  signed Q16 group sum.
- m_tvalid  out  1  FIFO non-empty.
- m_tready  in  1  downstream ready.
- m_tlast  out  1  this sum closes the frame.
- overflow  out  1  sticky: a result was dropped on a full FIFO.
- grp_cnt  out  16  number of groups pushed since reset, wraps at 2^16.

## Operation
- Reset values: m_tvalid=0, m_tlast=0, m_tdata=0, overflow=0, grp_cnt=0, FIFO empty, state IDLE, term counter=0, accumulator=0.
- State machine:
  - IDLE: no partial group.
  - ACCUM: partial group of 1..GROUP_LEN-1 terms held.
- IDLE with s_tvalid:
  - acc ← sign-extended s_tdata; cnt ← 1.
  - If GROUP_LEN==1 or s_tlast, close immediately and stay in IDLE.
  - Otherwise go to ACCUM.
- ACCUM with s_tvalid:
  - acc ← acc + sext(s_tdata); cnt ← cnt+1.
  - Close when cnt+1==GROUP_LEN or s_tlast, then return to IDLE.
- Close:
  - Registered result = narrow(final acc) is pushed next cycle with last flag = s_tlast of the closing beat.
  - grp_cnt increments on every successful push.
- s_tlast on a partial group: the partial sum is emitted with m_tlast=1. Next beat starts a new group.
- No s_tvalid: state, acc and cnt hold. Gaps inside a group are allowed.
- Narrowing is defined under Configuration. Arithmetic is two's complement; the accumulator never wraps inside ACC_WIDTH at legal parameters.
- FIFO full at push:
  - With no pop in the same cycle, the result is dropped and overflow is set.
  - With a simultaneous pop (m_tvalid & m_tready), the push is accepted.
- overflow clears only on reset.
- Reset mid-group: the partial sum is discarded and FIFO contents are lost.

## Timing
- The closing beat is sampled on edge N. The result is registered on N+1, written into the FIFO on N+2, and m_tvalid is high after N+2. Latency is 2 cycles.
- Sustained throughput: one term per cycle in, one result per cycle out when m_tready=1.
- m_tdata and m_tlast are stable while m_tvalid=1 and m_tready=0. A beat transfers on an edge with m_tvalid & m_tready.
- Empty FIFO: m_tvalid=0, and m_tdata holds its last value (don't-care).

## Configuration
- GRAD_ACCUM_SAT_EN defined:
  - Narrowing saturates to [−2^(OUT_WIDTH−1), 2^(OUT_WIDTH−1)−1].
  - An extra sticky bit sat_hit (output, reset 0) sets on any clamp.
- Undefined:
  - Narrowing takes acc[OUT_WIDTH−1:0] (wrap).
  - The sat_hit port is absent.

## Structure
- Package grad_pkg holds:
  - Q16 constants (Q16_ONE=32'h0001_0000).
  - State enum (IDLE, ACCUM).
  - Default widths.
  - A clog2 helper function.
- Sub-module grad_fifo holds:
  - Synchronous single-clock FIFO of {last, data}, with registered output, full/empty flags and simultaneous read/write.
  - Async active-low reset on aclk/aresetn.
- Top-level holds the FSM, accumulator, narrowing and counters.

## Test plan
- Basic group: GROUP_LEN=3, terms 0x00010000, 0x00020000, 0xFFFF0000 → one beat m_tdata=0x00020000, m_tlast=0, 2 cycles after the third term; grp_cnt=1.
- Partial frame: two terms 0x00008000, 0x00008000 with s_tlast on the second → m_tdata=0x00010000, m_tlast=1. The next term starts a fresh group.
- Saturation: three terms 0x7FFFFFFF.
  - With GRAD_ACCUM_SAT_EN: m_tdata=0x7FFFFFFF and sat_hit=1.
  - Without: m_tdata=0x7FFFFFFD.
- Backpressure: m_tready=0 and 17 groups closed with FIFO_DEPTH=16 → 16 entries held, overflow=1, grp_cnt=16. Draining yields the first 16 sums in order.
- Full with simultaneous pop: FIFO full, m_tready=1 in the push cycle → push accepted and overflow stays 0.
- Reset mid-group: one term in, aresetn pulsed low → all outputs at reset values. Three new terms of 0x00010000 → m_tdata=0x00030000.
